// File: rtl/rx_dllp_pkg.sv
// Shared DLLP type codes, CRC constants and the 32-bit CRC-16 helper for the
// RX-side DLLP transmit queue.
package rx_dllp_pkg;

  localparam logic [7:0]  DLLP_ACK = 8'h00;
  localparam logic [7:0]  DLLP_NAK = 8'h10;
  localparam logic [15:0] CRC_POLY = 16'h100B;
  localparam logic [15:0] CRC_SEED = 16'hFFFF;

  typedef struct packed {
    logic [7:0]  dtype;
    logic [11:0] rsvd;
    logic [11:0] seq;
  } dllp_t;

  // Bit-serial CRC unrolled over the word, MSB first, inverted result
  function automatic logic [15:0] crc16_dllp(input logic [31:0] d);
    logic [15:0] c;
    logic        fb;
    c = CRC_SEED;
    for (int i = 31; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ CRC_POLY;
    end
    return ~c;
  endfunction

endpackage

// File: rtl/dllp_crc16.sv
// Combinational CRC-16 over one 32-bit DLLP body.
module dllp_crc16
  import rx_dllp_pkg::*;
(
  input  logic [31:0] data_i,
  output logic [15:0] crc_o
);

  assign crc_o = crc16_dllp(data_i);

endmodule

// File: rtl/rx_dllp_tx_queue.sv
// Circular DLLP queue between RX data link layer and the link transmitter;
// back-to-back ACKs collapse into the tail entry so only the newest sequence goes out.
module rx_dllp_tx_queue
  import rx_dllp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                dllp_i,
  input  logic                       dllp_valid_i,
  output logic                       dllp_ready_o,
  output logic [47:0]                frame_o,
  output logic                       frame_valid_o,
  input  logic                       frame_ready_i,
  output logic [15:0]                coalesce_cnt_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, tail_ptr;
  logic [LW-1:0] level;
  logic [15:0]   cnt;
  logic [31:0]   head;
  logic [15:0]   crc;
  dllp_t         in_d, tail_d;
  logic          push_fire, pop_fire, coalesce, push;

  assign tail_ptr = wr_ptr - 1'b1;
  assign in_d     = dllp_t'(dllp_i);
  assign tail_d   = dllp_t'(mem[tail_ptr]);
  assign head     = mem[rd_ptr];

  // Ready depends only on registered level, never on frame_ready_i
  assign dllp_ready_o  = level < LW'(DEPTH);
  assign frame_valid_o = level != '0;
  assign push_fire     = dllp_valid_i && dllp_ready_o;
  assign pop_fire      = frame_valid_o && frame_ready_i;

  // A lone tail that is leaving this cycle cannot absorb the new ACK
  assign coalesce = push_fire && (in_d.dtype == DLLP_ACK) && (level != '0) &&
                    (tail_d.dtype == DLLP_ACK) && !(pop_fire && level == LW'(1));
  assign push     = push_fire && !coalesce;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      cnt    <= '0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop_fire})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (coalesce && cnt != 16'hFFFF) cnt <= cnt + 1'b1;
    end
  end

  // Storage is left unreset; every read is qualified by level
  always_ff @(posedge clk) begin
    if (push)          mem[wr_ptr]        <= dllp_i;
    else if (coalesce) mem[tail_ptr][11:0] <= dllp_i[11:0];
  end

  dllp_crc16 u_crc (
    .data_i (head),
    .crc_o  (crc)
  );

  assign frame_o        = frame_valid_o ? {head, crc} : 48'h0;
  assign coalesce_cnt_o = cnt;
  assign level_o        = level;

endmodule
